// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Writeback arbiter for the register bank write port, plus a
//            pending-write scoreboard used by decode for RAW/WAW stalls.
//            Define ARB_FIXED_PRIO_EN for fixed-priority arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [XLEN*NREQ-1:0] req_data,
    input  logic                 iss_valid,
    input  logic [4:0]           iss_rd,
    output logic                 iss_ready,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [31:0]          busy_vec,
    output logic                 reg_we,
    output logic [4:0]           rd,
    output logic [XLEN-1:0]      rd_val
);

    localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CAND_W = PTR_W + 1;

    logic [NREQ-1:0]  w_gnt;
    logic             w_gnt_any;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_start;
    logic [4:0]       w_sel_rd;
    logic [XLEN-1:0]  w_sel_data;

    logic             reg_we_q;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  rd_val_q;
    logic [31:0]      busy_q;
    logic [31:0]      busy_d;

`ifdef ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (w_gnt_any) begin
            ptr_d = (w_gnt_idx == PTR_W'(NREQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_start = ptr_q;
`endif

    // Search from w_start, wrapping modulo NREQ; nothing is granted in reset.
    always_comb begin : arb_search
        logic [CAND_W-1:0] cand;
        cand      = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = {1'b0, w_start} + CAND_W'(off);
            if (cand >= CAND_W'(NREQ)) begin
                cand = cand - CAND_W'(NREQ);
            end
            if (rst_n && !w_gnt_any && req_valid[cand[PTR_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt      = '0;
        w_sel_rd   = '0;
        w_sel_data = '0;
        if (w_gnt_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_rd   = req_rd[5*i +: 5];
                w_sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    assign req_ready = w_gnt;

    assign iss_ready = rst_n & ((iss_rd == 5'd0) | ~busy_q[iss_rd]);

    // Clear first so a same-edge issue to the same register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (reg_we_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (iss_valid && iss_ready && (iss_rd != 5'd0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we_q <= 1'b0;
            rd_q     <= '0;
            rd_val_q <= '0;
            busy_q   <= '0;
        end else begin
            reg_we_q <= w_gnt_any && (w_sel_rd != 5'd0);
            if (w_gnt_any) begin
                rd_q     <= w_sel_rd;
                rd_val_q <= w_sel_data;
            end
            busy_q <= busy_d;
        end
    end

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign busy_vec = busy_q;
    assign reg_we   = reg_we_q;
    assign rd       = rd_q;
    assign rd_val   = rd_val_q;

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the 32x32 register bank among NREQ writeback requesters (ALU, load unit, CSR unit), one granted write per cycle. Holds a 32-entry pending-write scoreboard that decode uses to stall on RAW and WAW hazards. Sits between the execute/writeback units and the register bank write port (reg_we/rd/rd_val); decode drives the issue interface and reads the busy flags.

Parameters:
NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU, 2 = CSR); legal range 2..8
XLEN, 32, data width of a writeback value

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  input  NREQ  per-requester writeback valid
req_ready  output  NREQ  per-requester grant; combinational, one-hot or zero
req_rd  input  5*NREQ  destination register per requester, slice i = [5i+4:5i]
req_data  input  XLEN*NREQ  writeback value per requester, slice i = [XLEN*i+XLEN-1:XLEN*i]
iss_valid  input  1  decode issuing an instruction that will write iss_rd
iss_rd  input  5  destination of the issuing instruction
iss_ready  output  1  issue accepted (no WAW conflict); combinational
rs1  input  5  decode source 1 address
rs2  input  5  decode source 2 address
rs1_busy  output  1  rs1 has a pending write; combinational
rs2_busy  output  1  rs2 has a pending write; combinational
busy_vec  output  32  scoreboard contents; bit 0 always 0
reg_we  output  1  register bank write enable; registered
rd  output  5  register bank write address; registered
rd_val  output  XLEN  register bank write data; registered

Behaviour:
- Reset (rst_n=0 at rising edge): reg_we=0, rd=0, rd_val=0, busy_vec=0, round-robin pointer=0. req_ready=0 and iss_ready=0 while rst_n=0. Reset taking effect mid-transaction discards any registered write (reg_we low next cycle).
- Arbitration: round-robin. Search starts at index ptr and wraps modulo NREQ; the first i with req_valid[i]=1 gets req_ready[i]=1. On a grant, ptr <= (granted index + 1) mod NREQ. With no valid request, ptr holds.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. Requesters hold valid, rd, and data stable until the transfer. Ungranted requesters wait; no data is dropped.
- Latency: 1 cycle. At the granting edge, reg_we <= (granted rd != 0), rd <= granted rd, rd_val <= granted data. With no grant, reg_we <= 0 and rd/rd_val hold.
- x0: a grant with rd=0 is accepted (req_ready=1) but produces reg_we=0.
- Scoreboard set: at an edge with iss_valid & iss_ready & iss_rd != 0, busy[iss_rd] <= 1.
- Scoreboard clear: at an edge with reg_we=1, busy[rd] <= 0. This is the same edge the bank captures the write, so rs*_busy drops exactly when the new value is readable.
- Set and clear of the same register at the same edge: set wins, so the bit stays 1.
- A write to a register that is not busy is still performed; the clear is a no-op.
- iss_ready = rst_n & ((iss_rd == 0) | ~busy[iss_rd]).
- rs1_busy = busy[rs1]; rs2_busy = busy[rs2]. Both are 0 for x0.
- Busy bits do not forward the in-flight rd_val.

Optional Feature:
ARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority (lowest valid index wins every cycle) and the round-robin pointer is removed. When undefined, round-robin as above. All other behaviour is identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles -> reg_we=0, rd=0, rd_val=0, busy_vec=0; after release with no requests, reg_we stays 0.
- Single write: iss x5 accepted -> busy_vec[5]=1. Next, req0 valid with rd=5, data=0xDEADBEEF -> req_ready[0]=1; next cycle reg_we=1, rd=5, rd_val=0xDEADBEEF; after that edge busy_vec[5]=0.
- Round-robin: all 3 requesters held valid with rd=1,2,3 -> grants 0,1,2,0 on consecutive cycles. With ARB_FIXED_PRIO_EN the grants are 0,0,0, and req1 is granted only once req0 drops.
- WAW stall: x7 busy, iss_valid with iss_rd=7 -> iss_ready=0. The cycle after x7's write posts, iss_ready=1.
- Set/clear collision: reg_we=1, rd=9 in the same cycle as an accepted issue of iss_rd=9 -> busy_vec[9] stays 1.
- x0 and mid-reset: req with rd=0, data=0x1234 -> req_ready=1, reg_we=0 next cycle. Grant at edge N, rst_n=0 at edge N+1 -> reg_we=0 and busy_vec=0 after N+1.
